// File: rtl/apb_2_axil_tmo.sv
// rtl/apb_2_axil_tmo.sv - single-clock APB slave to AXI4-Lite master bridge with response timeout
// Optional: define APB_2_AXIL_TMO_PROT_EN to forward pprot onto aw.prot/ar.prot.
package apb_2_axil_tmo_pkg;
   typedef struct packed {
      logic [31:0] paddr;
      logic [2:0]  pprot;
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
   } apb_req_t;
   typedef struct packed {
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } apb_resp_t;
   typedef struct packed { logic [31:0] addr; logic [2:0] prot; } axi_a_t;
   typedef struct packed { logic [31:0] data; logic [3:0] strb; } axi_w_t;
   typedef struct packed { logic [1:0] resp; } axi_b_t;
   typedef struct packed { logic [31:0] data; logic [1:0] resp; } axi_r_t;
   typedef struct packed {
      axi_a_t aw;
      logic   aw_valid;
      axi_w_t w;
      logic   w_valid;
      logic   b_ready;
      axi_a_t ar;
      logic   ar_valid;
      logic   r_ready;
   } axi_req_t;
   typedef struct packed {
      logic   aw_ready;
      logic   w_ready;
      axi_b_t b;
      logic   b_valid;
      logic   ar_ready;
      axi_r_t r;
      logic   r_valid;
   } axi_resp_t;
endpackage

module apb_2_axil_tmo #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter type apb_req_t  = apb_2_axil_tmo_pkg::apb_req_t,
   parameter type apb_resp_t = apb_2_axil_tmo_pkg::apb_resp_t,
   parameter type axi_req_t  = apb_2_axil_tmo_pkg::axi_req_t,
   parameter type axi_resp_t = apb_2_axil_tmo_pkg::axi_resp_t
) (
   input  logic      clk_i,
   input  logic      arst_i,
   input  apb_req_t  apb_req_i,
   output apb_resp_t apb_resp_o,
   output axi_req_t  axi_req_o,
   input  axi_resp_t axi_resp_i
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, ADDR, RESP, DONE, DRAIN} state_e;
   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, prdata_q;
   logic [STRB_WIDTH-1:0] strb_q;
   logic [2:0]            prot;
   logic write_q, pslverr_q, tmo_q;
   logic aw_done_q, w_done_q, ar_done_q, rsp_done_q;

   logic capture, chan_act, rsp_act;
   logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs, addr_ok, rsp_hs;
   logic tmo_hit, tmo_fire;

   assign capture  = (state_q == IDLE) && apb_req_i.psel && apb_req_i.penable;
   // The DONE cycle after a timeout still owns the open channels so no valid glitches low.
   assign chan_act = (state_q == ADDR) || (state_q == RESP) || (state_q == DRAIN) ||
                     ((state_q == DONE) && tmo_q);
   assign rsp_act  = chan_act && (state_q != ADDR);

   assign aw_valid = chan_act && write_q && !aw_done_q;
   assign w_valid  = chan_act && write_q && !w_done_q;
   assign ar_valid = chan_act && !write_q && !ar_done_q;
   assign b_ready  = rsp_act && write_q && aw_done_q && w_done_q && !rsp_done_q;
   assign r_ready  = rsp_act && !write_q && ar_done_q && !rsp_done_q;

   assign aw_hs   = aw_valid && axi_resp_i.aw_ready;
   assign w_hs    = w_valid && axi_resp_i.w_ready;
   assign ar_hs   = ar_valid && axi_resp_i.ar_ready;
   assign b_hs    = b_ready && axi_resp_i.b_valid;
   assign r_hs    = r_ready && axi_resp_i.r_valid;
   assign rsp_hs  = b_hs || r_hs;
   assign addr_ok = write_q ? ((aw_done_q || aw_hs) && (w_done_q || w_hs)) : (ar_done_q || ar_hs);

   assign tmo_fire = tmo_hit && (((state_q == ADDR) && !addr_ok) || ((state_q == RESP) && !rsp_hs));

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_tmo
         localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);
         localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
         logic [CW-1:0] cnt_q;
         always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) begin
               cnt_q <= '0;
            end else if (capture) begin
               cnt_q <= '0;
            end else if (((state_q == ADDR) || (state_q == RESP)) && (cnt_q != TMO_MAX)) begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
         assign tmo_hit = ((state_q == ADDR) || (state_q == RESP)) && (cnt_q >= TMO_LAST);
      end else begin : g_no_tmo
         assign tmo_hit = 1'b0;
      end
   endgenerate

`ifdef APB_2_AXIL_TMO_PROT_EN
   logic [2:0] prot_q;
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) prot_q <= '0;
      else if (capture) prot_q <= apb_req_i.pprot;
   end
   assign prot = prot_q;
`else
   logic [2:0] unused_pprot;
   assign unused_pprot = apb_req_i.pprot;
   assign prot = 3'b000;
`endif

   logic unused_resp;
   assign unused_resp = ^{axi_resp_i.b.resp[0], axi_resp_i.r.resp[0]};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (capture) state_d = ADDR;
         ADDR:    if (addr_ok) state_d = RESP; else if (tmo_fire) state_d = DONE;
         RESP:    if (rsp_hs || tmo_fire) state_d = DONE;
         DONE:    state_d = tmo_q ? DRAIN : IDLE;
         DRAIN:   if (rsp_done_q || rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
         write_q    <= 1'b0;
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
         tmo_q      <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         ar_done_q  <= 1'b0;
         rsp_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q     <= apb_req_i.paddr;
            wdata_q    <= apb_req_i.pwdata;
            strb_q     <= apb_req_i.pstrb;
            write_q    <= apb_req_i.pwrite;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            tmo_q      <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ar_done_q  <= 1'b0;
            rsp_done_q <= 1'b0;
         end else begin
            if (aw_hs)  aw_done_q  <= 1'b1;
            if (w_hs)   w_done_q   <= 1'b1;
            if (ar_hs)  ar_done_q  <= 1'b1;
            if (rsp_hs) rsp_done_q <= 1'b1;
            // Responses arriving while draining are discarded: only RESP updates the APB result.
            if ((state_q == RESP) && rsp_hs) begin
               pslverr_q <= write_q ? axi_resp_i.b.resp[1] : axi_resp_i.r.resp[1];
               prdata_q  <= write_q ? '0 : axi_resp_i.r.data;
            end else if (tmo_fire) begin
               pslverr_q <= 1'b1;
               prdata_q  <= '0;
               tmo_q     <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      axi_req_o          = '0;
      axi_req_o.aw.addr  = addr_q;
      axi_req_o.aw.prot  = prot;
      axi_req_o.aw_valid = aw_valid;
      axi_req_o.w.data   = wdata_q;
      axi_req_o.w.strb   = strb_q;
      axi_req_o.w_valid  = w_valid;
      axi_req_o.b_ready  = b_ready;
      axi_req_o.ar.addr  = addr_q;
      axi_req_o.ar.prot  = prot;
      axi_req_o.ar_valid = ar_valid;
      axi_req_o.r_ready  = r_ready;
      apb_resp_o         = '0;
      apb_resp_o.pready  = (state_q == DONE);
      apb_resp_o.prdata  = prdata_q;
      apb_resp_o.pslverr = pslverr_q;
   end
endmodule

// File: tb/tb_apb_2_axil_tmo.sv
// tb/tb_apb_2_axil_tmo.sv - randomized self-checking bench for apb_2_axil_tmo
module tb_apb_2_axil_tmo;
   import apb_2_axil_tmo_pkg::*;

   localparam int TMO = 8;

   logic      clk = 1'b0;
   logic      arst = 1'b1;
   apb_req_t  apb_req;
   apb_resp_t apb_resp;
   axi_req_t  axi_req;
   axi_resp_t axi_resp;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   apb_2_axil_tmo #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk), .arst_i(arst),
      .apb_req_i(apb_req), .apb_resp_o(apb_resp),
      .axi_req_o(axi_req), .axi_resp_i(axi_resp)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // AXI-Lite slave: each channel readies/responds after a configured number of cycles
   int cfg_daw, cfg_dw, cfg_dar, cfg_db, cfg_dr;
   logic [31:0] cfg_rdata;
   logic [1:0]  cfg_rresp, cfg_bresp;
   int n_aw, n_w, n_ar, n_b, n_r;
   int age_aw, age_w, age_ar, age_b, age_r;
   int hi_aw, hi_w, hi_ar;
   int rise_aw, rise_w, rise_ar, r_hs_cyc, stab_err;
   logic [31:0] rec_aw_addr, rec_w_data, rec_ar_addr;
   logic [3:0]  rec_w_strb;
   logic [2:0]  rec_ar_prot;
   axi_req_t  p_req;
   axi_resp_t p_rsp;
   logic      p_rst;

   task automatic slave_clear();
      n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0;
      age_aw = 0; age_w = 0; age_ar = 0; age_b = 0; age_r = 0;
      axi_resp = '0; p_req = '0; p_rsp = '0;
   endtask

   initial begin
      stab_err = 0; p_rst = 1'b1;
      slave_clear();
      forever begin
         @(negedge clk);
         if (arst) begin
            slave_clear(); p_rst = 1'b1;
         end else if (p_rst) begin
            slave_clear(); p_rst = 1'b0;
         end else begin
            if (p_req.aw_valid && p_rsp.aw_ready) begin n_aw++; age_aw = 0; end
            else if (p_req.aw_valid && !axi_req.aw_valid) stab_err++;
            if (p_req.w_valid && p_rsp.w_ready) begin n_w++; age_w = 0; end
            else if (p_req.w_valid && !axi_req.w_valid) stab_err++;
            if (p_req.ar_valid && p_rsp.ar_ready) begin n_ar++; age_ar = 0; end
            else if (p_req.ar_valid && !axi_req.ar_valid) stab_err++;
            if (p_rsp.b_valid && p_req.b_ready) begin n_b++; age_b = 0; end
            if (p_rsp.r_valid && p_req.r_ready) begin n_r++; age_r = 0; r_hs_cyc = cyc - 1; end

            if (axi_req.aw_valid && !p_req.aw_valid) begin rise_aw = cyc; rec_aw_addr = axi_req.aw.addr; end
            if (axi_req.w_valid && !p_req.w_valid) begin
               rise_w = cyc; rec_w_data = axi_req.w.data; rec_w_strb = axi_req.w.strb;
            end
            if (axi_req.ar_valid && !p_req.ar_valid) begin
               rise_ar = cyc; rec_ar_addr = axi_req.ar.addr; rec_ar_prot = axi_req.ar.prot;
            end
            if (axi_req.aw_valid) hi_aw++;
            if (axi_req.w_valid) hi_w++;
            if (axi_req.ar_valid) hi_ar++;

            axi_resp = '0;
            axi_resp.aw_ready = axi_req.aw_valid && (age_aw >= cfg_daw);
            axi_resp.w_ready  = axi_req.w_valid && (age_w >= cfg_dw);
            axi_resp.ar_ready = axi_req.ar_valid && (age_ar >= cfg_dar);
            if (axi_req.aw_valid && !axi_resp.aw_ready) age_aw++;
            if (axi_req.w_valid && !axi_resp.w_ready) age_w++;
            if (axi_req.ar_valid && !axi_resp.ar_ready) age_ar++;
            if (n_aw > n_b && n_w > n_b) begin
               axi_resp.b_valid = (age_b >= cfg_db);
               if (!axi_resp.b_valid) age_b++;
            end
            if (n_ar > n_r) begin
               axi_resp.r_valid = (age_r >= cfg_dr);
               if (!axi_resp.r_valid) age_r++;
            end
            axi_resp.b.resp = cfg_bresp;
            axi_resp.r.data = cfg_rdata;
            axi_resp.r.resp = cfg_rresp;
            p_req = axi_req;
            p_rsp = axi_resp;
         end
      end
   end

   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot,
                           output int t_acc, output int t_rdy, output logic [31:0] rd, output logic err);
      @(negedge clk);
      apb_req.paddr = addr; apb_req.pwdata = data; apb_req.pstrb = strb; apb_req.pprot = prot;
      apb_req.pwrite = wr; apb_req.psel = 1'b1; apb_req.penable = 1'b0;
      @(negedge clk);
      apb_req.penable = 1'b1;
      t_acc = cyc; t_rdy = -1; rd = '0; err = 1'b0;
      for (int k = 0; k < 200 && t_rdy < 0; k++) begin
         @(negedge clk);
         if (apb_resp.pready) begin t_rdy = cyc; rd = apb_resp.prdata; err = apb_resp.pslverr; end
      end
      @(negedge clk);
      check("pready_pulse", apb_resp.pready, 1'b0);
      apb_req.psel = 1'b0; apb_req.penable = 1'b0;
   endtask

   // Reference: zero-wait latency is 3, plus the slowest address channel and the response wait.
   task automatic run_one(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input int daw, input int dw, input int dar, input int db, input int dr,
                          input logic [31:0] rdata, input logic [1:0] resp);
      int t_acc, t_rdy, lat, b0;
      logic [31:0] rd;
      logic err;
      logic [2:0] exp_prot;
      cfg_daw = daw; cfg_dw = dw; cfg_dar = dar; cfg_db = db; cfg_dr = dr;
      cfg_rdata = rdata; cfg_rresp = resp; cfg_bresp = resp;
      hi_aw = 0; hi_w = 0; hi_ar = 0; b0 = n_b;
      apb_xfer(wr, addr, data, strb, prot, t_acc, t_rdy, rd, err);
      lat = wr ? 3 + ((daw > dw) ? daw : dw) + db : 3 + dar + dr;
      check({tag, "_latency"}, t_rdy - t_acc, lat);
      check({tag, "_prdata"}, rd, wr ? 32'h0 : rdata);
      check({tag, "_pslverr"}, err, resp[1]);
      if (wr) begin
         check({tag, "_aw_rise"}, rise_aw, t_acc + 1);
         check({tag, "_w_rise"}, rise_w, t_acc + 1);
         check({tag, "_aw_held"}, hi_aw, daw + 1);
         check({tag, "_w_held"}, hi_w, dw + 1);
         check({tag, "_aw_addr"}, rec_aw_addr, addr);
         check({tag, "_w_data"}, {rec_w_strb, rec_w_data}, {strb, data});
         check({tag, "_b_count"}, n_b - b0, 1);
      end else begin
`ifdef APB_2_AXIL_TMO_PROT_EN
         exp_prot = prot;
`else
         exp_prot = 3'b000;
`endif
         check({tag, "_ar_rise"}, rise_ar, t_acc + 1);
         check({tag, "_ar_held"}, hi_ar, dar + 1);
         check({tag, "_ar_addr"}, rec_ar_addr, addr);
         check({tag, "_ar_prot"}, rec_ar_prot, exp_prot);
      end
   endtask

   initial begin
      int t_acc, t_rdy, t2_acc, t2_rdy;
      logic [31:0] rd, rd2;
      logic err, err2;
      apb_req = '0;
      cfg_daw = 0; cfg_dw = 0; cfg_dar = 0; cfg_db = 0; cfg_dr = 0;
      cfg_rdata = '0; cfg_rresp = '0; cfg_bresp = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {apb_resp, axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                              axi_req.ar_valid, axi_req.r_ready}, '0);
      arst = 1'b0;
      @(negedge clk);
      check("post_reset_outputs", {apb_resp, axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                                   axi_req.ar_valid, axi_req.r_ready}, '0);

      run_one("wr_zero_wait", 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, 0, 0, 32'h0, 2'b00);
      run_one("rd_ar_stall", 1'b0, 32'h2004, 32'h0, 4'h0, 3'b000, 0, 0, 5, 0, 0, 32'h12345678, 2'b10);
      run_one("wr_w_first", 1'b1, 32'h1008, 32'hA5A5_0F0F, 4'h3, 3'b000, 3, 0, 0, 0, 0, 32'h0, 2'b00);
      run_one("rd_prot", 1'b0, 32'h200C, 32'h0, 4'h0, 3'b011, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 2'b00);

      for (int i = 0; i < 24; i++) begin
         run_one("rand", 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom, 2'($urandom_range(0, 3)));
      end

      // Read whose slave never accepts the address within the timeout window
      cfg_dar = 1000; cfg_dr = 2; cfg_rdata = 32'h5555_AAAA; cfg_rresp = 2'b00;
      cfg_daw = 0; cfg_dw = 0; cfg_db = 0; cfg_bresp = 2'b00;
      apb_xfer(1'b0, 32'h3000, 32'h0, 4'h0, 3'b000, t_acc, t_rdy, rd, err);
      check("tmo_latency", t_rdy - t_acc, 1 + TMO);
      check("tmo_pslverr", err, 1'b1);
      check("tmo_prdata", rd, 32'h0);
      check("tmo_ar_still_valid", axi_req.ar_valid, 1'b1);
      r_hs_cyc = -100;
      fork
         apb_xfer(1'b1, 32'h3100, 32'h0BAD_F00D, 4'hF, 3'b000, t2_acc, t2_rdy, rd2, err2);
         begin
            repeat (5) @(negedge clk);
            cfg_dar = 0;
         end
      join
      check("drain_next_ready", t2_rdy, r_hs_cyc + 4);
      check("drain_next_pslverr", err2, 1'b0);
      check("drain_next_prdata", rd2, 32'h0);

      // Reset while a write waits for its response
      cfg_daw = 0; cfg_dw = 0; cfg_db = 1000; cfg_bresp = 2'b00;
      @(negedge clk);
      apb_req.paddr = 32'h4000; apb_req.pwdata = 32'h1111_2222; apb_req.pstrb = 4'hF;
      apb_req.pwrite = 1'b1; apb_req.psel = 1'b1; apb_req.penable = 1'b0;
      @(negedge clk);
      apb_req.penable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_resp_bready", axi_req.b_ready, 1'b1);
      #1 arst = 1'b1;
      #1;
      check("rst_mid_outputs", {apb_resp, axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                                axi_req.ar_valid, axi_req.r_ready}, '0);
      @(negedge clk);
      apb_req.psel = 1'b0; apb_req.penable = 1'b0;
      @(negedge clk);
      arst = 1'b0;
      run_one("after_rst_rd", 1'b0, 32'h4004, 32'h0, 4'h0, 3'b000, 0, 0, 1, 0, 1, 32'h7777_8888, 2'b00);
      run_one("after_rst_wr", 1'b1, 32'h4008, 32'h9999_0000, 4'hC, 3'b000, 1, 2, 0, 1, 0, 32'h0, 2'b10);

      check("valid_stable", stab_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
